// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//
// Steps through a pattern memory of note words and plays them one at a time
// through an external duration counter. Each memory word holds an end flag,
// a 5-bit duration and a pitch. A note lasts duration+1 time-base ticks; a
// pitch of zero is a rest, so the gate stays low. An end word either restarts
// the pattern from address 0 (i_loop=1) or finishes playback with a one-cycle
// o_end pulse (i_loop=0). The end word itself is never played.
//
// State table
//   state  | meaning
//   IDLE   | stopped, address parked at 0, waiting for i_start
//   FETCH  | address presented to the pattern memory, data arrives next cycle
//   DECODE | memory word valid: end marker handling or latch duration/pitch
//   LOAD   | wait for the counter to be free, load it on the next tick
//   PLAY   | note sounding until the counter reports done
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          asynchronous active-high reset
//   i_tick         one-cycle time-base pulse
//   i_start        start playback from address 0 (ignored while busy)
//   i_stop         abort playback, wins over every other input
//   i_loop         behaviour on an end marker: 1 restart, 0 stop
//   o_rom_addr     registered pattern-memory address
//   i_rom_data     pattern word {end, duration[4:0], pitch}
//   o_dur_enable   counter enable, follows i_tick combinationally
//   o_dur_load     counter load request
//   o_dur_value    duration to load into the counter
//   i_dur_done     counter done pulse
//   i_dur_running  counter running flag
//   o_pitch        current note pitch, holds outside PLAY
//   o_gate         note sounding
//   o_busy         high in every state except IDLE
//   o_end          one-cycle pulse when playback stops on an end marker
// ---------------------------------------------------------------------------
module note_sequencer #(
    parameter int ADDR_WIDTH  = 6,
    parameter int PITCH_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tick,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_loop,
    output logic [ADDR_WIDTH-1:0]  o_rom_addr,
    input  logic [PITCH_WIDTH+5:0] i_rom_data,
    output logic                   o_dur_enable,
    output logic                   o_dur_load,
    output logic [4:0]             o_dur_value,
    input  logic                   i_dur_done,
    input  logic                   i_dur_running,
    output logic [PITCH_WIDTH-1:0] o_pitch,
    output logic                   o_gate,
    output logic                   o_busy,
    output logic                   o_end
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        LOAD   = 3'd3,
        PLAY   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [4:0]             dur_q, dur_d;
    logic [PITCH_WIDTH-1:0] pitch_lat_q, pitch_lat_d;
    logic [PITCH_WIDTH-1:0] pitch_q, pitch_d;

    logic                   rom_end;
    logic [4:0]             rom_dur;
    logic [PITCH_WIDTH-1:0] rom_pitch;

    assign rom_end   = i_rom_data[PITCH_WIDTH+5];
    assign rom_dur   = i_rom_data[PITCH_WIDTH+4:PITCH_WIDTH];
    assign rom_pitch = i_rom_data[PITCH_WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            dur_q       <= '0;
            pitch_lat_q <= '0;
            pitch_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dur_q       <= dur_d;
            pitch_lat_q <= pitch_lat_d;
            pitch_q     <= pitch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dur_d       = dur_q;
        pitch_lat_d = pitch_lat_q;
        pitch_d     = pitch_q;
        o_dur_load  = 1'b0;
        o_gate      = 1'b0;
        o_end       = 1'b0;

        // Stop overrides everything, including a pending start or done pulse.
        // The counter may keep running after an abort; LOAD waits it out.
        if (i_stop) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_d = '0;
                    if (i_start) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    state_d = DECODE;
                end
                DECODE: begin
                    if (rom_end) begin
                        addr_d = '0;
                        if (i_loop) begin
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                            o_end   = 1'b1;
                        end
                    end else begin
                        dur_d       = rom_dur;
                        pitch_lat_d = rom_pitch;
                        state_d     = LOAD;
                    end
                end
                LOAD: begin
                    // Load is held until the tick so the counter starts on the
                    // same time-base edge the note does.
                    o_dur_load = ~i_dur_running;
                    if (i_tick && !i_dur_running) begin
                        state_d = PLAY;
                        pitch_d = pitch_lat_q;
                    end
                end
                PLAY: begin
                    o_gate = |pitch_q;
                    if (i_dur_done) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    assign o_rom_addr   = addr_q;
    assign o_dur_enable = i_tick;
    assign o_dur_value  = dur_q;
    assign o_pitch      = pitch_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, pattern-memory address width.
REQ-002 Parameter PITCH_WIDTH, default 8, pitch field width.
REQ-003 Port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 Port i_tick  input  1  one-cycle time-base pulse for the duration counter.
REQ-006 Port i_start  input  1  start playback from address 0.
REQ-007 Port i_stop  input  1  abort playback.
REQ-008 Port i_loop  input  1  on end marker: 1 = restart at address 0, 0 = stop.
REQ-009 Port o_rom_addr  output  ADDR_WIDTH  pattern-memory read address, registered.
REQ-010 Port i_rom_data  input  PITCH_WIDTH+6  memory word, valid one cycle after o_rom_addr changes; [PITCH_WIDTH+5] end flag, [PITCH_WIDTH+4:PITCH_WIDTH] duration, [PITCH_WIDTH-1:0] pitch.
REQ-011 Port o_dur_enable  output  1  enable to the duration counter; combinationally equal to i_tick.
REQ-012 Port o_dur_load  output  1  load request to the duration counter.
REQ-013 Port o_dur_value  output  5  duration to load.
REQ-014 Port i_dur_done  input  1  duration counter done pulse.
REQ-015 Port i_dur_running  input  1  duration counter running flag.
REQ-016 Port o_pitch  output  PITCH_WIDTH  current note pitch.
REQ-017 Port o_gate  output  1  note sounding.
REQ-018 Port o_busy  output  1  high in every state except IDLE.
REQ-019 Port o_end  output  1  one-cycle pulse when playback ends on an end marker with i_loop=0.

Function
REQ-020 States IDLE, FETCH, DECODE, LOAD, PLAY; one transition per clock.
REQ-021 IDLE: o_rom_addr=0; i_start=1 and i_stop=0 -> FETCH.
REQ-022 FETCH: unconditionally -> DECODE; i_rom_data sampled in DECODE.
REQ-023 DECODE, end flag=1: i_loop=1 -> address 0, FETCH; i_loop=0 -> address 0, IDLE, o_end=1 that cycle; end word never played.
REQ-024 DECODE, end flag=0: latch duration and pitch fields -> LOAD.
REQ-025 LOAD: o_dur_load = ~i_dur_running; o_dur_value = latched duration; i_tick=1 and i_dur_running=0 -> PLAY, o_pitch updated to latched pitch.
REQ-026 PLAY: o_gate=1 iff o_pitch != 0 (pitch 0 = rest); i_dur_done=1 -> address+1 mod 2^ADDR_WIDTH, FETCH.
REQ-027 o_gate=0 and o_dur_load=0 outside the conditions above; o_pitch holds its last value outside PLAY.
REQ-028 Note length = duration+1 ticks (counter semantics); duration 0 plays exactly 1 tick.
REQ-029 i_stop=1 in any state -> IDLE next cycle, address 0, o_gate=0, no o_end; i_stop wins over i_start and i_dur_done.
REQ-030 i_start ignored while o_busy=1.
REQ-031 Address wrap: 2^ADDR_WIDTH-1 -> 0 with no end marker; playback continues.
REQ-032 After stop with counter still running, next start waits in LOAD until i_dur_running=0; no load issued while running.

Reset
REQ-033 i_rst=1 -> immediately IDLE, address 0, o_pitch=0, latched duration 0, o_gate=0, o_dur_load=0, o_busy=0, o_end=0, independent of i_clk.
REQ-034 Reset mid-PLAY abandons the note; no o_end pulse.

Verification
REQ-035 Pattern {pitch 0x40 dur 2},{end}, i_loop=0, i_tick every 4 clocks, start -> o_gate high exactly 3 ticks with o_pitch=0x40, then o_end single pulse, o_busy=0.
REQ-036 Same pattern, i_loop=1 -> o_rom_addr sequence 0,1,0,1...; no o_end; note replays.
REQ-037 Word {pitch 0 dur 0} -> PLAY lasts 1 tick, o_gate=0 throughout.
REQ-038 i_stop pulsed mid-PLAY, i_start 2 cycles later while counter running -> o_dur_load stays 0 until i_dur_running=0, then note at address 0 plays.
REQ-039 ADDR_WIDTH=2, no end markers, 4 notes dur 0 -> addresses 0,1,2,3,0 in order.
REQ-040 i_rst asserted between clock edges during PLAY -> all outputs 0 before next edge; i_start and i_stop together -> stays IDLE.
